// File: rtl/ysyx_24080014_ifu_pkg.sv
// Shared definitions for the instruction fetch unit: FSM states, fault codes,
// AXI response codes and the reset PC.
package ysyx_24080014_ifu_pkg;

  typedef enum logic [1:0] {
    S_AR      = 2'd0,
    S_R       = 2'd1,
    S_SEND    = 2'd2,
    S_WAIT_PC = 2'd3
  } state_e;

  localparam logic [1:0]  FAULT_NONE     = 2'd0;
  localparam logic [1:0]  FAULT_MISALIGN = 2'd1;
  localparam logic [1:0]  FAULT_BUS      = 2'd2;
  localparam logic [1:0]  RESP_OKAY      = 2'b00;
  localparam logic [31:0] RESET_PC       = 32'h8000_0000;

  function automatic logic [1:0] resp_to_fault(input logic [1:0] resp);
    return (resp != RESP_OKAY) ? FAULT_BUS : FAULT_NONE;
  endfunction

  function automatic logic pc_misaligned(input logic [1:0] pc_lo);
    return (pc_lo != 2'b00);
  endfunction

endpackage

// File: rtl/ysyx_24080014_ifu_if.sv
// AXI4-Lite read channel (AR + R) between the IFU and the instruction SRAM.
interface ysyx_24080014_ifu_if #(
  parameter int XLEN = 32
);
  logic            arvalid;
  logic            arready;
  logic [XLEN-1:0] araddr;
  logic            rvalid;
  logic            rready;
  logic [XLEN-1:0] rdata;
  logic [1:0]      rresp;

  modport master (
    output arvalid, araddr, rready,
    input  arready, rvalid, rdata, rresp
  );

  modport slave (
    input  arvalid, araddr, rready,
    output arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/ysyx_24080014_ifu.sv
// Multi-cycle instruction fetch unit: one AXI-Lite read per PC, hands
// {pc, inst, fault} to decode and waits for the committed next PC.
module ysyx_24080014_ifu
  import ysyx_24080014_ifu_pkg::*;
#(
  parameter int               XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = ysyx_24080014_ifu_pkg::RESET_PC
) (
  input  logic                   clk,
  input  logic                   rst,
  ysyx_24080014_ifu_if.master    axi,
  output logic                   inst_valid,
  input  logic                   inst_ready,
  output logic [XLEN-1:0]        inst_pc,
  output logic [XLEN-1:0]        inst,
  output logic [1:0]             inst_fault,
  input  logic                   npc_valid,
  input  logic [XLEN-1:0]        npc,
  output logic [31:0]            perf_fetch_cnt
);

  state_e          state_r, state_s;
  logic [XLEN-1:0] pc_r, pc_s;
  logic            arvalid_r, arvalid_s;
  logic            rready_r, rready_s;
  logic            inst_valid_r, inst_valid_s;
  logic [XLEN-1:0] inst_r, inst_s;
  logic [1:0]      fault_r, fault_s;
  logic [31:0]     cnt_r, cnt_s;

  // State, PC and all output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= S_AR;
      pc_r         <= RESET_PC;
      arvalid_r    <= 1'b0;
      rready_r     <= 1'b0;
      inst_valid_r <= 1'b0;
      inst_r       <= {XLEN{1'b0}};
      fault_r      <= FAULT_NONE;
      cnt_r        <= 32'd0;
    end else begin
      state_r      <= state_s;
      pc_r         <= pc_s;
      arvalid_r    <= arvalid_s;
      rready_r     <= rready_s;
      inst_valid_r <= inst_valid_s;
      inst_r       <= inst_s;
      fault_r      <= fault_s;
      cnt_r        <= cnt_s;
    end
  end

  // Next-state and next-PC selection
  always_comb begin
    state_s = state_r;
    pc_s    = pc_r;
    case (state_r)
      S_AR: begin
        if (pc_misaligned(pc_r[1:0])) begin
          state_s = S_SEND;
        end else if (arvalid_r && axi.arready) begin
          state_s = S_R;
        end else begin
          state_s = S_AR;
        end
      end
      S_R: begin
        if (rready_r && axi.rvalid) begin
          state_s = S_SEND;
        end else begin
          state_s = S_R;
        end
      end
      S_SEND: begin
        if (inst_valid_r && inst_ready) begin
          state_s = S_WAIT_PC;
        end else begin
          state_s = S_SEND;
        end
      end
      S_WAIT_PC: begin
        if (npc_valid) begin
          state_s = S_AR;
          pc_s    = npc;
        end else begin
          state_s = S_WAIT_PC;
        end
      end
      default: begin
        state_s = S_AR;
        pc_s    = RESET_PC;
      end
    endcase
  end

  // Outputs are decoded from the next state so every port comes straight from a flop
  always_comb begin
    arvalid_s    = (state_s == S_AR) && !pc_misaligned(pc_s[1:0]);
    rready_s     = (state_s == S_R);
    inst_valid_s = (state_s == S_SEND);
    inst_s       = inst_r;
    fault_s      = fault_r;
    cnt_s        = cnt_r;
    case (state_r)
      S_AR: begin
        if (pc_misaligned(pc_r[1:0])) begin
          inst_s  = {XLEN{1'b0}};
          fault_s = FAULT_MISALIGN;
        end else begin
          fault_s = fault_r;
        end
      end
      S_R: begin
        if (rready_r && axi.rvalid) begin
          fault_s = resp_to_fault(axi.rresp);
          inst_s  = (axi.rresp == RESP_OKAY) ? axi.rdata : {XLEN{1'b0}};
        end else begin
          fault_s = fault_r;
        end
      end
      S_SEND: begin
        if (inst_valid_r && inst_ready) begin
          cnt_s = cnt_r + 32'd1;
        end else begin
          cnt_s = cnt_r;
        end
      end
      S_WAIT_PC: begin
        cnt_s = cnt_r;
      end
      default: begin
        cnt_s = cnt_r;
      end
    endcase
  end

  assign axi.arvalid    = arvalid_r;
  assign axi.araddr     = pc_r;
  assign axi.rready     = rready_r;
  assign inst_valid     = inst_valid_r;
  assign inst_pc        = pc_r;
  assign inst           = inst_r;
  assign inst_fault     = fault_r;
  assign perf_fetch_cnt = cnt_r;

endmodule
